// File: rtl/cam_capture_module.sv
// Camera byte-stream capture: packs byte pairs into RGB565 words, crops each frame
// to H_ACTIVE x V_ACTIVE and writes whole frames into the display pixel FIFO.
module cam_capture_module #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 16,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        cam_byte_valid,
  input  logic [7:0]  cam_data,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [15:0] fifo_wr_data,
  output logic        frame_done,
  output logic        overflow
);

  localparam logic [10:0] H_LIM    = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM    = 11'(V_ACTIVE);
  localparam logic [10:0] COL_MAX  = 11'd2047;
  localparam logic [3:0]  SKIP_LIM = 4'(SKIP_FRAMES);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, DONE} state_t;

  state_t      state_reg;
  logic        vsync_d_reg;
  logic        href_d_reg;
  logic        phase_reg;
  logic        line_word_reg;
  logic [7:0]  hi_byte_reg;
  logic [10:0] col_reg;
  logic [10:0] row_reg;
  logic [3:0]  skip_cnt_reg;

  logic vs_rise;
  logic vs_fall;
  logic href_fall;
  logic byte_take;
  logic in_window;

  assign vs_rise   = cam_vsync & ~vsync_d_reg;
  assign vs_fall   = ~cam_vsync & vsync_d_reg;
  assign href_fall = ~cam_href & href_d_reg;
  assign byte_take = cam_href & cam_byte_valid;
  assign in_window = (col_reg < H_LIM) && (row_reg < V_LIM);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg     <= IDLE;
      vsync_d_reg   <= 1'b0;
      href_d_reg    <= 1'b0;
      phase_reg     <= 1'b0;
      line_word_reg <= 1'b0;
      hi_byte_reg   <= 8'd0;
      col_reg       <= 11'd0;
      row_reg       <= 11'd0;
      skip_cnt_reg  <= 4'd0;
      fifo_wr_en    <= 1'b0;
      fifo_wr_data  <= 16'd0;
      frame_done    <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      vsync_d_reg <= cam_vsync;
      href_d_reg  <= cam_href;
      fifo_wr_en  <= 1'b0;
      frame_done  <= 1'b0;
      case (state_reg)
        // Only a rising vsync arms capture, so a frame already running at reset is skipped.
        IDLE: begin
          if (vs_rise) state_reg <= SYNC;
        end
        SYNC: begin
          if (vs_fall) begin
            if (skip_cnt_reg < SKIP_LIM) begin
              skip_cnt_reg <= skip_cnt_reg + 4'd1;
              state_reg    <= IDLE;
            end else begin
              row_reg       <= 11'd0;
              col_reg       <= 11'd0;
              phase_reg     <= 1'b0;
              line_word_reg <= 1'b0;
              overflow      <= 1'b0;
              state_reg     <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            state_reg  <= SYNC;
            frame_done <= 1'b1;
          end else if (row_reg >= V_LIM) begin
            state_reg  <= DONE;
            frame_done <= 1'b1;
          end else if (href_fall) begin
            // End of line: a dangling high byte is simply forgotten by clearing phase.
            if (line_word_reg) row_reg <= row_reg + 11'd1;
            col_reg       <= 11'd0;
            phase_reg     <= 1'b0;
            line_word_reg <= 1'b0;
          end else if (byte_take) begin
            if (!phase_reg) begin
              hi_byte_reg <= cam_data;
              phase_reg   <= 1'b1;
            end else begin
              phase_reg     <= 1'b0;
              line_word_reg <= 1'b1;
              if (col_reg != COL_MAX) col_reg <= col_reg + 11'd1;
              if (in_window) begin
                if (fifo_full) begin
                  overflow <= 1'b1;
                end else begin
                  fifo_wr_en   <= 1'b1;
                  fifo_wr_data <= {hi_byte_reg, cam_data};
                end
              end
            end
          end
        end
        DONE: begin
          if (vs_rise) state_reg <= SYNC;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_module.sv
// Directed bench for cam_capture_module: a frame table (skip, crop, fifo_full drops,
// odd byte count, truncated frame) plus a mid-frame reset sequence.
module tb_cam_capture_module;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int SK = 2;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic        cam_byte_valid = 1'b0;
  logic [7:0]  cam_data = 8'd0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic        frame_done;
  logic        overflow;

  cam_capture_module #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SK)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_byte_valid(cam_byte_valid), .cam_data(cam_data),
    .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int   lines;
    int   bpl;
    int   full_row;
    int   full_s;
    int   full_n;
    int   exp_writes;
    logic exp_ovf;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          wr_count = 0;
  int          done_count = 0;
  bit          prev_wr = 1'b0;
  bit          prev_done = 1'b0;
  int          skips_left = SK;
  logic [7:0]  bcnt = 8'd0;
  logic [7:0]  hi_b = 8'd0;
  logic [15:0] first_w [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: sample DUT outputs on the falling edge and score writes/pulses.
  task automatic tick();
    @(negedge CLK);
    if (fifo_wr_en) begin
      wr_count++;
      if (wr_count <= 2) first_w[wr_count-1] = fifo_wr_data;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h required=none", fifo_wr_data);
      end else begin
        check("wr_data", fifo_wr_data, exp_q.pop_front());
      end
      check("wr_en_gap", 32'(prev_wr), 0);
    end
    prev_wr = fifo_wr_en;
    if (frame_done) begin
      done_count++;
      check("done_width", 32'(prev_done), 0);
    end
    prev_done = frame_done;
  endtask

  task automatic drive_line(input bit cap, input int row, input int nbytes,
                            input int full_s, input int full_n, input int gap);
    for (int k = 0; k < nbytes; k++) begin
      tick();
      cam_href       = 1'b1;
      cam_byte_valid = 1'b1;
      cam_data       = bcnt;
      fifo_full      = (k >= full_s) && (k < full_s + full_n);
      if ((k % 2) == 0) hi_b = bcnt;
      else if (cap && row < V && (k / 2) < H && !fifo_full) exp_q.push_back({hi_b, bcnt});
      bcnt = bcnt + 8'd1;
    end
    for (int g = 0; g < gap; g++) begin
      tick();
      cam_href       = 1'b0;
      cam_byte_valid = 1'b0;
      fifo_full      = 1'b0;
    end
  endtask

  task automatic frame_start(output bit cap);
    tick();
    cam_vsync = 1'b1;
    repeat (4) tick();
    cam_vsync = 1'b0;
    cap = (skips_left == 0);
    if (!cap) skips_left--;
    bcnt = 8'd0;
    repeat (3) tick();
    if (cap) check("ovf_clear", 32'(overflow), 0);
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    bit cap;
    wr_count = 0;
    frame_start(cap);
    for (int r = 0; r < v.lines; r++)
      drive_line(cap, r, v.bpl, v.full_s, (r == v.full_row) ? v.full_n : 0, 4);
    check("writes", 32'(wr_count), 32'(v.exp_writes));
    check("overflow", 32'(overflow), 32'(v.exp_ovf));
    check("pending", 32'(exp_q.size()), 0);
    if (idx == 2) begin
      check("first_word", first_w[0], 16'h0001);
      check("second_word", first_w[1], 16'h0203);
    end
    $display("frame %0d capture=%0b lines=%0d bpl=%0d writes=%0d overflow=%0b",
             idx, cap, v.lines, v.bpl, wr_count, overflow);
  endtask

  vec_t tbl [7];
  vec_t skip_v;
  vec_t cap_v;

  initial begin
    int  done_before;
    bit  cap;
    tbl[0] = '{lines: 5, bpl: 20, full_row: -1, full_s: 0, full_n: 0,  exp_writes: 0,  exp_ovf: 1'b0};
    tbl[1] = '{lines: 5, bpl: 20, full_row: -1, full_s: 0, full_n: 0,  exp_writes: 0,  exp_ovf: 1'b0};
    tbl[2] = '{lines: 5, bpl: 20, full_row: -1, full_s: 0, full_n: 0,  exp_writes: 32, exp_ovf: 1'b0};
    tbl[3] = '{lines: 5, bpl: 20, full_row: 2,  full_s: 4, full_n: 10, exp_writes: 27, exp_ovf: 1'b1};
    tbl[4] = '{lines: 4, bpl: 17, full_row: -1, full_s: 0, full_n: 0,  exp_writes: 32, exp_ovf: 1'b0};
    tbl[5] = '{lines: 2, bpl: 16, full_row: -1, full_s: 0, full_n: 0,  exp_writes: 16, exp_ovf: 1'b0};
    tbl[6] = '{lines: 4, bpl: 16, full_row: -1, full_s: 0, full_n: 0,  exp_writes: 32, exp_ovf: 1'b0};
    skip_v = '{lines: 4, bpl: 16, full_row: -1, full_s: 0, full_n: 0, exp_writes: 0,  exp_ovf: 1'b0};
    cap_v  = '{lines: 4, bpl: 16, full_row: -1, full_s: 0, full_n: 0, exp_writes: 32, exp_ovf: 1'b0};

    // Reset state
    repeat (3) tick();
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_wr_data", 32'(fifo_wr_data), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_overflow", 32'(overflow), 0);
    RSTn = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 7; i++) run_frame(tbl[i], i);
    check("done_count", 32'(done_count), 5);

    // Reset in the middle of a captured line while a write is on the bus
    frame_start(cap);
    check("mid_cap", 32'(cap), 1);
    drive_line(cap, 0, 16, 0, 0, 4);
    drive_line(cap, 1, 16, 2, 2, 4);
    drive_line(cap, 2, 6, 0, 0, 0);
    tick();
    check("wr_en_before_rst", 32'(fifo_wr_en), 1);
    check("ovf_before_rst", 32'(overflow), 1);
    RSTn = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(fifo_wr_en), 0);
    check("mid_rst_wr_data", 32'(fifo_wr_data), 0);
    check("mid_rst_frame_done", 32'(frame_done), 0);
    check("mid_rst_overflow", 32'(overflow), 0);
    exp_q.delete();
    skips_left = SK;
    wr_count = 0;
    repeat (2) tick();
    RSTn = 1'b1;
    // Released with vsync low and href high: the rest of this frame must be ignored
    drive_line(1'b0, 2, 10, 0, 0, 4);
    drive_line(1'b0, 3, 16, 0, 0, 4);
    check("no_write_after_rst", 32'(wr_count), 0);
    check("no_done_after_rst", 32'(frame_done), 0);
    run_frame(skip_v, 7);
    run_frame(skip_v, 8);
    done_before = done_count;
    run_frame(cap_v, 9);
    check("done_after_rst", 32'(done_count - done_before), 1);

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
